// File: rtl/multi_track_recorder.sv
`default_nettype none
// ============================================================================
// Module   : multi_track_recorder
// Purpose  : NUM_TRACKS independent key-event recorders/players. Each track
//            stores {key, hold duration in ticks} entries taken from the
//            shared decoded keyboard code. It replays them with the original
//            timing and can optionally loop.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   CLOCK_50    in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   key_in      in   live decoded key code (0 = silence)
//   track_sel   in   track addressed by the command pulses
//   cmd_record  in   pulse: (re)start recording the selected track
//   cmd_play    in   pulse: start playback of the selected track
//   cmd_stop    in   pulse: stop the selected track
//   loop_en     in   per-track loop enable, sampled at end of track
//   play_key    out  per-track playback key, track t at [t*KEY_W +: KEY_W]
//   track_state out  per-track state (0 IDLE, 1 RECORD, 2 PLAY)
//   track_len   out  per-track stored event count
//   overflow    out  per-track sticky "recording filled the track"
//   tick        out  one-cycle timing tick strobe
// ============================================================================
module multi_track_recorder #(
  parameter int NUM_TRACKS = 4,
  parameter int DEPTH      = 256,
  parameter int KEY_W      = 7,
  parameter int DUR_W      = 12,
  parameter int TICK_DIV   = 500000,
  localparam int SEL_W     = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1,
  localparam int LEN_W     = $clog2(DEPTH) + 1
) (
  input  logic                        CLOCK_50,
  input  logic                        reset,
  input  logic [KEY_W-1:0]            key_in,
  input  logic [SEL_W-1:0]            track_sel,
  input  logic                        cmd_record,
  input  logic                        cmd_play,
  input  logic                        cmd_stop,
  input  logic [NUM_TRACKS-1:0]       loop_en,
  output logic [NUM_TRACKS*KEY_W-1:0] play_key,
  output logic [2*NUM_TRACKS-1:0]     track_state,
  output logic [NUM_TRACKS*LEN_W-1:0] track_len,
  output logic [NUM_TRACKS-1:0]       overflow,
  output logic                        tick
);

  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENT_W  = KEY_W + DUR_W;
  localparam int CNT_W  = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [DUR_W-1:0] DUR_MAX  = '1;
  localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECORD = 2'd1,
    ST_PLAY   = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Shared prescaler. tick_q is high exactly while cnt_q == TICK_DIV-1.
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  always_comb begin
    cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    tick_d = (cnt_d == CNT_LAST);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

  // --------------------------------------------------------------------------
  // Per-track recorder / player
  // --------------------------------------------------------------------------
  for (genvar t = 0; t < NUM_TRACKS; t++) begin : g_track
    state_t           state_q, state_d;
    logic [LEN_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, len_q, len_d;
    logic [LEN_W-1:0] rd_nxt;
    logic [KEY_W-1:0] cur_key_q, cur_key_d, play_key_q, play_key_d;
    logic [DUR_W-1:0] dur_q, dur_d, elapsed_q, elapsed_d;
    logic [DUR_W-1:0] dur_inc, el_inc, close_dur, stop_dur, cur_dur;
    logic [KEY_W-1:0] nxt_key, first_key;
    logic             ovf_q, ovf_d, sel, wr_en;
    logic [ENT_W-1:0] wr_data;
    logic [ENT_W-1:0] mem [DEPTH];

    assign sel       = (track_sel == SEL_W'(t));
    assign rd_nxt    = rd_ptr_q + 1'b1;
    assign cur_dur   = mem[rd_ptr_q[ADDR_W-1:0]][DUR_W-1:0];
    assign nxt_key   = mem[rd_nxt[ADDR_W-1:0]][ENT_W-1 -: KEY_W];
    assign first_key = mem[0][ENT_W-1 -: KEY_W];
    // A tick on the closing cycle still belongs to the entry being closed.
    assign dur_inc   = dur_q + DUR_W'(tick_q);
    assign el_inc    = elapsed_q + 1'b1;
    // Zero-length entries would never advance on playback, so clamp to 1.
    assign close_dur = (dur_inc == '0) ? DUR_W'(1) : dur_inc;
    assign stop_dur  = (dur_q == '0) ? DUR_W'(1) : dur_q;

    always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      len_d      = len_q;
      cur_key_d  = cur_key_q;
      play_key_d = play_key_q;
      dur_d      = dur_q;
      elapsed_d  = elapsed_q;
      ovf_d      = ovf_q;
      wr_en      = 1'b0;
      wr_data    = '0;

      if (sel && cmd_stop) begin
        if (state_q == ST_RECORD) begin
          // Flush the pending entry; RECORD always has room left.
          wr_en   = 1'b1;
          wr_data = {cur_key_q, stop_dur};
          len_d   = wr_ptr_q + 1'b1;
          state_d = ST_IDLE;
        end else if (state_q == ST_PLAY) begin
          state_d    = ST_IDLE;
          play_key_d = '0;
        end
      end else if (sel && cmd_record) begin
        // Old contents are abandoned: length drops to 0 until the new take ends.
        state_d    = ST_RECORD;
        wr_ptr_d   = '0;
        cur_key_d  = key_in;
        dur_d      = '0;
        ovf_d      = 1'b0;
        play_key_d = '0;
        len_d      = '0;
      end else if (sel && cmd_play && (state_q != ST_RECORD) && (len_q != '0)) begin
        state_d    = ST_PLAY;
        rd_ptr_d   = '0;
        elapsed_d  = '0;
        play_key_d = first_key;
      end else begin
        case (state_q)
          ST_RECORD: begin
            if ((key_in != cur_key_q) || (dur_inc == DUR_MAX)) begin
              // Key change closes the entry; saturation splits it and keeps cur_key.
              wr_en     = 1'b1;
              wr_data   = {cur_key_q, close_dur};
              wr_ptr_d  = wr_ptr_q + 1'b1;
              cur_key_d = key_in;
              dur_d     = '0;
              if (wr_ptr_q == LEN_FULL - 1'b1) begin
                state_d = ST_IDLE;
                len_d   = LEN_FULL;
                ovf_d   = 1'b1;
              end
            end else begin
              dur_d = dur_inc;
            end
          end
          ST_PLAY: begin
            if (tick_q) begin
              if (el_inc == cur_dur) begin
                elapsed_d = '0;
                if (rd_nxt == len_q) begin
                  if (loop_en[t]) begin
                    rd_ptr_d   = '0;
                    play_key_d = first_key;
                  end else begin
                    state_d    = ST_IDLE;
                    play_key_d = '0;
                  end
                end else begin
                  rd_ptr_d   = rd_nxt;
                  play_key_d = nxt_key;
                end
              end else begin
                elapsed_d = el_inc;
              end
            end
          end
          default: ;
        endcase
      end
    end

    always_ff @(posedge CLOCK_50) begin
      if (reset) begin
        state_q    <= ST_IDLE;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        len_q      <= '0;
        cur_key_q  <= '0;
        play_key_q <= '0;
        dur_q      <= '0;
        elapsed_q  <= '0;
        ovf_q      <= 1'b0;
      end else begin
        state_q    <= state_d;
        wr_ptr_q   <= wr_ptr_d;
        rd_ptr_q   <= rd_ptr_d;
        len_q      <= len_d;
        cur_key_q  <= cur_key_d;
        play_key_q <= play_key_d;
        dur_q      <= dur_d;
        elapsed_q  <= elapsed_d;
        ovf_q      <= ovf_d;
      end
    end

    // Event storage: no reset, contents only meaningful below len_q.
    always_ff @(posedge CLOCK_50) begin
      if (!reset && wr_en) begin
        mem[wr_ptr_q[ADDR_W-1:0]] <= wr_data;
      end
    end

    assign play_key[t*KEY_W +: KEY_W]  = play_key_q;
    assign track_state[2*t +: 2]       = state_q;
    assign track_len[t*LEN_W +: LEN_W] = len_q;
    assign overflow[t]                 = ovf_q;
  end

endmodule
`default_nettype wire
